// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- memory / writeback stage of the 5-stage RV32 pipeline.
//
// Takes one instruction per ex_valid/ex_ready handshake. Non-memory ops retire
// on the following cycle. Loads and stores are issued over a req/gnt/rvalid
// data-memory port. The stage holds ex_ready low until the transaction
// completes. Loads are lane-aligned and sign/zero extended before writeback.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned LH/LHU/SH
// (addr[0]=1) and LW/SW (addr[1:0]!=0). A trapped access issues no memory
// request and retires with misalign_err set. When the macro is undefined,
// misaligned accesses are issued using the truncated lane rules.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   ex_*             instruction from execute (valid/ready handshake)
//   dmem_*           data-memory request/grant/response interface
//   wb_valid         retire pulse
//   reg_wren         register-file write enable (pulse)
//   wb_tag, wb_data  register-file write address/data (held between retires)
//   misalign_err     misaligned-access trap pulse (0 without MISALIGN_TRAP_EN)

module mem_wb_stage #(
  parameter int word_width     = 32,
  parameter int reg_addr_width = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [word_width-1:0]     ex_alu_result,
  input  logic [word_width-1:0]     ex_store_data,
  input  logic [reg_addr_width-1:0] ex_rd_tag,
  input  logic                      ex_reg_wren,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [2:0]                ex_funct3,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [word_width-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [word_width-1:0]     dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [word_width-1:0]     dmem_rdata,
  output logic                      wb_valid,
  output logic                      reg_wren,
  output logic [reg_addr_width-1:0] wb_tag,
  output logic [word_width-1:0]     wb_data,
  output logic                      misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                    state_q;
  logic                      req_q, we_q, wb_valid_q, reg_wren_q, misalign_q;
  logic [word_width-1:0]     addr_q, wdata_q, wb_data_q;
  logic [3:0]                be_q;
  logic [2:0]                funct3_q;
  logic [1:0]                off_q;
  logic [reg_addr_width-1:0] rd_q, wb_tag_q;
  logic                      is_mem, mis_trap;

  // Pick the addressed lane and extend it according to funct3.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  b);
    logic signed [7:0]  byt;
    logic signed [15:0] half;
    logic signed [31:0] sx;
    logic [31:0]        r;
    byt  = w[{b, 3'b000} +: 8];
    half = b[1] ? w[31:16] : w[15:0];
    sx   = '0;
    case (f3)
      3'b000:  begin sx = byt;  r = sx; end
      3'b100:  r = {24'd0, byt};
      3'b001:  begin sx = half; r = sx; end
      3'b101:  r = {16'd0, half};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] b);
    case (f3[1:0])
      2'b00:   return 4'b0001 << b;
      2'b01:   return 4'b0011 << {b[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store datum across all lanes so any byte-enable pattern
  // picks up the right bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  assign is_mem = ex_mem_read | ex_mem_write;

`ifdef MISALIGN_TRAP_EN
  assign mis_trap = (ex_funct3[1:0] == 2'b01 && ex_alu_result[0]) ||
                    (ex_funct3[1:0] == 2'b10 && ex_alu_result[1:0] != 2'b00);
`else
  assign mis_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      reg_wren_q <= 1'b0;
      misalign_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      // Retire strobes are single-cycle pulses.
      wb_valid_q <= 1'b0;
      reg_wren_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_tag_q   <= ex_rd_tag;
              wb_data_q  <= ex_alu_result;
              reg_wren_q <= ex_reg_wren && (ex_rd_tag != '0);
            end else if (mis_trap) begin
              wb_valid_q <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q  <= REQ;
              req_q    <= 1'b1;
              // Read wins when both flags are set.
              we_q     <= ex_mem_write && !ex_mem_read;
              addr_q   <= {ex_alu_result[word_width-1:2], 2'b00};
              be_q     <= store_be(ex_funct3, ex_alu_result[1:0]);
              wdata_q  <= store_wdata(ex_funct3, ex_store_data);
              funct3_q <= ex_funct3;
              off_q    <= ex_alu_result[1:0];
              rd_q     <= ex_rd_tag;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            req_q <= 1'b0;
            if (we_q) begin
              state_q    <= IDLE;
              wb_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_tag_q   <= rd_q;
            reg_wren_q <= (rd_q != '0);
            wb_data_q  <= load_extract(dmem_rdata, funct3_q, off_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign reg_wren     = reg_wren_q;
  assign wb_tag       = wb_tag_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd_tag;
  logic        ex_reg_wren, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, reg_wren;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.word_width(32), .reg_addr_width(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd_tag(ex_rd_tag), .ex_reg_wren(ex_reg_wren),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .reg_wren(reg_wren), .wb_tag(wb_tag),
    .wb_data(wb_data), .misalign_err(misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: value written back for a load, from plain shift/mod arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
    int unsigned v, b;
    b = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * b)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (b / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_be(input logic [31:0] a, input logic [2:0] f3);
    int unsigned b;
    b = a % 4;
    if (f3 % 4 == 0) return 32'(1 << b);
    if (f3 % 4 == 1) return 32'(3 << (2 * (b / 2)));
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [31:0] d, input logic [2:0] f3);
    if (f3 % 4 == 0) return (d % 256) * 32'h0101_0101;
    if (f3 % 4 == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] res, input logic wren);
    chk("alu_ready", ex_ready, 1);
    ex_valid = 1; ex_mem_read = 0; ex_mem_write = 0;
    ex_rd_tag = rd; ex_alu_result = res; ex_reg_wren = wren;
    ex_funct3 = 3'($urandom_range(0, 7));
    step();
    ex_valid = 0;
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_tag", wb_tag, rd);
    chk("alu_wb_data", wb_data, res);
    chk("alu_reg_wren", reg_wren, (wren && rd != 0));
    chk("alu_misalign", misalign_err, 0);
  endtask

  // One memory transaction with gd REQ cycles before grant and rvd WAIT
  // cycles before rvalid. rv_in_req raises a stray rvalid while in REQ.
  task automatic do_mem(input logic rd_f, input logic wr_f, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] d, input logic [4:0] rd,
                        input int gd, input int rvd, input logic rv_in_req);
    logic [31:0] expa;
    expa = a & 32'hFFFF_FFFC;
    ex_valid = 1; ex_mem_read = rd_f; ex_mem_write = wr_f;
    ex_alu_result = a; ex_store_data = d; ex_funct3 = f3; ex_rd_tag = rd;
    ex_reg_wren = rd_f;
    step();
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
`ifdef MISALIGN_TRAP_EN
    if ((f3 % 4 == 1 && a % 2 == 1) || (f3 % 4 == 2 && a % 4 != 0)) begin
      chk("trap_req", dmem_req, 0);
      chk("trap_wb_valid", wb_valid, 1);
      chk("trap_reg_wren", reg_wren, 0);
      chk("trap_err", misalign_err, 1);
      chk("trap_ready", ex_ready, 1);
      step();
      chk("trap_err_pulse", misalign_err, 0);
      return;
    end
`endif
    chk("mem_req", dmem_req, 1);
    chk("mem_addr", dmem_addr, expa);
    chk("mem_we", dmem_we, !rd_f);
    chk("mem_ready_lo", ex_ready, 0);
    if (!rd_f) begin
      chk("st_be", dmem_be, ref_be(a, f3));
      chk("st_wdata", dmem_wdata, ref_wd(d, f3));
    end
    if (rv_in_req) begin dmem_rvalid = 1; dmem_rdata = ~d; end
    for (int i = 0; i < gd; i++) begin
      step();
      chk("req_hold", dmem_req, 1);
      chk("req_addr_hold", dmem_addr, expa);
      chk("req_we_hold", dmem_we, !rd_f);
      if (!rd_f) begin
        chk("req_be_hold", dmem_be, ref_be(a, f3));
        chk("req_wdata_hold", dmem_wdata, ref_wd(d, f3));
      end
      chk("req_no_wb", wb_valid, 0);
    end
    dmem_gnt = 1;
    step();
    dmem_gnt = 0; dmem_rvalid = 0;
    chk("gnt_req_drop", dmem_req, 0);
    if (!rd_f) begin
      chk("st_wb_valid", wb_valid, 1);
      chk("st_reg_wren", reg_wren, 0);
      chk("st_ready", ex_ready, 1);
      chk("st_misalign", misalign_err, 0);
      return;
    end
    chk("ld_wait_no_wb", wb_valid, 0);
    chk("ld_wait_ready", ex_ready, 0);
    for (int i = 0; i < rvd; i++) begin
      step();
      chk("ld_wait_no_wb", wb_valid, 0);
      chk("ld_wait_ready", ex_ready, 0);
    end
    dmem_rvalid = 1; dmem_rdata = d;
    step();
    dmem_rvalid = 0;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_tag", wb_tag, rd);
    chk("ld_wb_data", wb_data, ref_load(d, a, f3));
    chk("ld_reg_wren", reg_wren, (rd != 0));
    chk("ld_ready", ex_ready, 1);
    chk("ld_misalign", misalign_err, 0);
  endtask

  initial begin
    rst_n = 0; ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_rd_tag = 0;
    ex_reg_wren = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    step(); step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_reg_wren", reg_wren, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_tag", wb_tag, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_ready", ex_ready, 1);
    rst_n = 1;
    step();

    // ALU retire, rd=0 suppression, back-to-back throughput.
    do_alu(5'd5, 32'h0000_1234, 1);
    do_alu(5'd0, 32'h0000_1234, 1);
    do_alu(5'd7, 32'hCAFE_0001, 0);
    step();
    chk("wb_pulse", wb_valid, 0);
    chk("wb_data_hold", wb_data, 32'hCAFE_0001);

    // Loads and stores from the directed list.
    do_mem(1, 0, 32'h0000_0103, 3'b000, 32'h80AA_BBCC, 5'd3, 0, 1, 0);
    do_mem(1, 0, 32'h0000_0103, 3'b100, 32'h80AA_BBCC, 5'd4, 0, 1, 0);
    do_mem(0, 1, 32'h0000_0202, 3'b001, 32'h1234_ABCD, 5'd0, 3, 0, 0);
    do_mem(1, 0, 32'h0000_0300, 3'b010, 32'hDEAD_BEEF, 5'd9, 1, 0, 1);
    do_mem(1, 1, 32'h0000_0402, 3'b001, 32'h8001_7FFF, 5'd10, 0, 0, 0);
    do_mem(1, 0, 32'h0000_0500, 3'b010, 32'h1111_2222, 5'd0, 0, 0, 0);

    // Reset while waiting for load data abandons the load.
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_alu_result = 32'h600;
    ex_funct3 = 3'b010; ex_rd_tag = 5'd12;
    step();
    ex_valid = 0; ex_mem_read = 0;
    dmem_gnt = 1;
    step();
    dmem_gnt = 0;
    rst_n = 0;
    step();
    chk("rstw_req", dmem_req, 0);
    chk("rstw_ready", ex_ready, 1);
    chk("rstw_wb_valid", wb_valid, 0);
    rst_n = 1; dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA;
    step();
    dmem_rvalid = 0;
    chk("rstw_late_rvalid", wb_valid, 0);
    step();
    chk("rstw_late_rvalid2", wb_valid, 0);
    chk("rstw_late_wren", reg_wren, 0);

`ifdef MISALIGN_TRAP_EN
    do_mem(1, 0, 32'h0000_0101, 3'b010, 32'h0, 5'd6, 0, 0, 0);
    do_mem(0, 1, 32'h0000_0103, 3'b001, 32'h0, 5'd0, 0, 0, 0);
`endif

    // Randomized mix against the reference model.
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)
        do_alu(5'($urandom), $urandom, 1'($urandom));
      else
        do_mem(kind == 1, kind == 2 || ($urandom_range(0, 7) == 0),
               $urandom, 3'($urandom), $urandom, 5'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
